// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo counter with wrap/saturate modes, terminal count,
// boundary-event pulse and sticky overflow. Async active-high reset.
module param_updown_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MODULUS   = 256,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam longint unsigned FULL_RANGE = longint'(1) << WIDTH;
  localparam int unsigned     MAX_INT    = MODULUS - 1;
  localparam logic [WIDTH-1:0] MAXV      = MAX_INT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RSTV      = RESET_VAL[WIDTH-1:0];

  if (MODULUS < 2 || longint'(MODULUS) > FULL_RANGE) begin : g_bad_modulus
    $error("param_updown_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("param_updown_counter: RESET_VAL must be below MODULUS");
  end

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_CLR,
    ACT_LOAD,
    ACT_STEP
  } act_t;

  act_t             act;
  logic             at_bound;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;

  // A full-range modulus can never exceed MAXV, so the clamp collapses away.
  if (longint'(MODULUS) == FULL_RANGE) begin : g_no_clamp
    assign load_clamped = load_val;
  end else begin : g_clamp
    assign load_clamped = (load_val > MAXV) ? MAXV : load_val;
  end

  always_comb begin
    act = ACT_HOLD;
    if (clr)       act = ACT_CLR;
    else if (load) act = ACT_LOAD;
    else if (en)   act = ACT_STEP;
  end

  assign at_bound = up ? (q == MAXV) : (q == '0);
  assign tc       = at_bound;

  always_comb begin
    step_val = q;
    if (at_bound) begin
      if (!SATURATE) step_val = up ? '0 : MAXV;
    end else begin
      step_val = up ? q + 1'b1 : q - 1'b1;
    end
  end

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf;
    unique case (act)
      ACT_CLR: begin
        q_nxt   = RSTV;
        ovf_nxt = 1'b0;
      end
      ACT_LOAD: q_nxt = load_clamped;
      ACT_STEP: begin
        q_nxt    = step_val;
        wrap_nxt = at_bound;
        ovf_nxt  = ovf | at_bound;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= RSTV;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
      ovf  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: one full-range 8-bit instance and
// two modulo-10 instances (wrap and saturate) sharing the same stimulus.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       reset, clr, en, up, load;
  logic [7:0] lv;

  logic [7:0] q8;
  logic       tc8, wrap8, ovf8;
  logic [3:0] qw, qs;
  logic       tcw, wrapw, ovfw, tcs, wraps, ovfs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0), .RESET_VAL(0)) u8 (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(lv), .q(q8), .tc(tc8), .wrap(wrap8), .ovf(ovf8));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VAL(0)) uw (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(lv[3:0]), .q(qw), .tc(tcw), .wrap(wrapw), .ovf(ovfw));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RESET_VAL(0)) us (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(lv[3:0]), .q(qs), .tc(tcs), .wrap(wraps), .ovf(ovfs));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int ew [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int es [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
  int dw [4]  = '{1, 0, 9, 8};
  int ds [4]  = '{1, 0, 0, 0};

  initial begin
    reset = 1'b1; clr = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; lv = '0;
    #1;
    chk("rst_q", 32'(q8), 0);
    chk("rst_wrap", 32'(wrap8), 0);
    chk("rst_ovf", 32'(ovf8), 0);

    // Async reset mid-count
    #11 reset = 1'b0; en = 1'b1; up = 1'b1;
    repeat (37) step();
    chk("count37", 32'(q8), 37);
    chk("uw_ovf_pre_reset", 32'(ovfw), 1);
    #3 reset = 1'b1;
    #1;
    chk("async_q", 32'(q8), 0);
    chk("async_wrap", 32'(wrap8), 0);
    chk("async_uw_ovf", 32'(ovfw), 0);
    chk("async_uw_q", 32'(qw), 0);
    #1 reset = 1'b0;
    step();
    chk("post_reset_q", 32'(q8), 1);

    // Up wrap / saturate from 0
    en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("upw_q", 32'(qw), 32'(ew[k]));
      chk("upw_wrap", 32'(wrapw), (k == 9) ? 1 : 0);
      chk("upw_ovf", 32'(ovfw), (k >= 9) ? 1 : 0);
      chk("upw_tc", 32'(tcw), (ew[k] == 9) ? 1 : 0);
      chk("ups_q", 32'(qs), 32'(es[k]));
      chk("ups_wrap", 32'(wraps), (k >= 9) ? 1 : 0);
    end

    // Down wrap / saturate from 2
    en = 1'b0; clr = 1'b1;
    step();
    chk("clr_ovf", 32'(ovfs), 0);
    clr = 1'b0; load = 1'b1; lv = 8'd2;
    step();
    load = 1'b0; up = 1'b0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("dnw_q", 32'(qw), 32'(dw[k]));
      chk("dnw_wrap", 32'(wrapw), (k == 2) ? 1 : 0);
      chk("dns_q", 32'(qs), 32'(ds[k]));
      chk("dns_wrap", 32'(wraps), (k >= 2) ? 1 : 0);
    end
    chk("dns_ovf", 32'(ovfs), 1);

    // Priority: clr beats load beats en
    en = 1'b0; load = 1'b1; lv = 8'd5; up = 1'b1;
    step();
    chk("pri_q5", 32'(qw), 5);
    chk("pri_ovf_kept", 32'(ovfw), 1);
    clr = 1'b1; load = 1'b1; lv = 8'd3; en = 1'b1;
    step();
    chk("pri_clr_q", 32'(qw), 0);
    chk("pri_clr_ovf", 32'(ovfw), 0);
    clr = 1'b0;
    step();
    chk("pri_load_q", 32'(qw), 3);

    // Load clamp and ovf stickiness across load
    en = 1'b0; lv = 8'd13;
    step();
    chk("clamp_q", 32'(qw), 9);
    chk("clamp_tc", 32'(tcw), 1);
    chk("clamp_wrap", 32'(wrapw), 0);
    load = 1'b0; en = 1'b1;
    step();
    chk("clamp_wrap_q", 32'(qw), 0);
    chk("clamp_wrap_pulse", 32'(wrapw), 1);
    chk("clamp_ovf_set", 32'(ovfw), 1);
    en = 1'b0; load = 1'b1; lv = 8'd4;
    step();
    chk("load4_q", 32'(qw), 4);
    chk("load4_ovf", 32'(ovfw), 1);
    load = 1'b0; clr = 1'b1;
    step();
    chk("clr_ovf2", 32'(ovfw), 0);
    chk("clr_q", 32'(qw), 0);
    clr = 1'b0;

    // Full-range load (no clamp) and natural rollover
    load = 1'b1; lv = 8'd255;
    step();
    chk("u8_load255", 32'(q8), 255);
    chk("u8_tc", 32'(tc8), 1);
    load = 1'b0; en = 1'b1;
    step();
    chk("u8_roll_q", 32'(q8), 0);
    chk("u8_roll_wrap", 32'(wrap8), 1);
    chk("u8_roll_ovf", 32'(ovf8), 1);

    // Enable hold
    en = 1'b0; load = 1'b1; lv = 8'd6;
    step();
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_q", 32'(qw), 6);
      chk("hold_wrap", 32'(wrapw), 0);
    end

    // tc follows up with no clock edge
    load = 1'b1; lv = 8'd0;
    step();
    load = 1'b0; up = 1'b1;
    #1;
    chk("tc_up_at0", 32'(tcw), 0);
    up = 1'b0;
    #1;
    chk("tc_dn_at0", 32'(tcw), 1);
    up = 1'b1;
    #1;
    chk("tc_up_again", 32'(tcw), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised synchronous up/down modulo counter. Generalised successor to the team's 8-bit ripple counter.
- Adds the following over that counter: configurable width and modulus, direction control, count enable, synchronous clear, parallel load, wrap or saturate mode, terminal-count/wrap flags and a sticky overflow flag.
- Single clock domain; fully synchronous except reset.
- Drop-in timebase/event counter for lab datapaths and clock-divider chains; the tc output of one instance drives en of the next.

Parameters:
- WIDTH, 8, counter width in bits.
- MODULUS, 256, count range is 0..MODULUS-1. Legal range is 2..2^WIDTH; elaboration error outside it.
- SATURATE, 0, 0 = wrap at the boundaries; 1 = hold at the boundary.
- RESET_VAL, 0, value loaded by reset and clr. Must be < MODULUS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear to RESET_VAL; also clears ovf.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- q  output  WIDTH  registered count.
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle boundary-event pulse.
- ovf  output  1  registered sticky overflow/underflow flag.

Behaviour:
- Reset (asynchronous, active-high), while reset=1:
  - q=RESET_VAL, wrap=0, ovf=0.
  - Takes effect immediately, with no clock needed, including mid-count.
  - First update happens on the first rising edge after reset deasserts.
- Priority on each rising edge: reset > clr > load > en. Only the highest-priority active action applies.
- clr: q<=RESET_VAL, wrap<=0, ovf<=0.
- load:
  - q<=load_val when load_val <= MODULUS-1; otherwise q<=MODULUS-1 (clamped).
  - wrap<=0; ovf unchanged.
  - en is ignored on that edge.
- en=1, no clr/load, counting up:
  - If q<MODULUS-1: q<=q+1, wrap<=0.
  - If q==MODULUS-1 and SATURATE=0: q<=0, wrap<=1, ovf<=1.
  - If q==MODULUS-1 and SATURATE=1: q holds, wrap<=1, ovf<=1.
- en=1, no clr/load, counting down:
  - If q>0: q<=q-1, wrap<=0.
  - If q==0 and SATURATE=0: q<=MODULUS-1, wrap<=1, ovf<=1.
  - If q==0 and SATURATE=1: q holds at 0, wrap<=1, ovf<=1.
- en=0: q holds, wrap<=0, ovf holds.
- tc = (up & q==MODULUS-1) | (~up & q==0).
  - Combinational from q and up; independent of en.
  - Toggling up changes tc in the same cycle.
- Arithmetic:
  - Comparisons use WIDTH bits.
  - With MODULUS=2^WIDTH, wrap is natural binary rollover. The same compare logic is used; no extra bit.
- up may change on any cycle. The direction sampled at the edge governs that edge's step.
- Once set, ovf remains 1 until clr or reset; load does not clear it.
- wrap never stays high two cycles unless boundary events occur on consecutive edges. Example: SATURATE=1 with en held at the boundary keeps wrap=1 every such cycle.
- Every output is fully defined for all input combinations; no X propagation from load_val when load=0.

Test Plan:
- Reset/async (WIDTH=8, MODULUS=256, RESET_VAL=0): count to q=37, then assert reset between clock edges -> q=0, wrap=0, ovf=0 immediately, before the next edge. After release, en=1, up=1 -> q=1 after the first edge.
- Up wrap (WIDTH=4, MODULUS=10, SATURATE=0): en=1, up=1 from 0 for 12 edges -> q sequence 1..9,0,1,2.
  - tc=1 while q=9.
  - wrap=1 exactly in the cycle q=0 appears.
  - ovf=1 from then on.
- Down wrap/saturate (MODULUS=10): load 2, then up=0, en=1 for 4 edges.
  - SATURATE=0 -> q 1,0,9,8; wrap pulses with q=9.
  - SATURATE=1 -> q 1,0,0,0; wrap=1 on the last two cycles; ovf=1.
- Priority (MODULUS=10): q=5, then on one edge clr=1, load=1, load_val=3, en=1 -> q=0, ovf=0. Next edge load=1, en=1 -> q=3 (not 4).
- Load clamp (WIDTH=4, MODULUS=10): load_val=13 -> q=9, tc=1 with up=1. Then set ovf, load 4 -> ovf stays 1; clr -> ovf=0.
- Enable/direction: q=6, en=0 for 5 edges -> q=6 held, wrap=0. Toggle up at q=0 with en=0 -> tc changes the same cycle, with no clock edge required.
